// File: rtl/lsu_bus_adapter_if.sv
// Bundle of request, memory-bus and response signals between an LSU and the bus adapter.
// The master side is the environment (LSU plus memory); the slave side is the adapter itself.
interface lsu_bus_adapter_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        write_enable;
  logic        read_enable;
  logic [1:0]  write_wstrb;
  logic [31:0] wb_mask;
  logic        load_unsigned;

  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;

  modport master (
    output req_valid, addr, wdata, write_enable, read_enable, write_wstrb, wb_mask,
           load_unsigned, mem_ready, mem_rvalid, mem_rdata, resp_ready,
    input  req_ready, mem_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
           resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, addr, wdata, write_enable, read_enable, write_wstrb, wb_mask,
           load_unsigned, mem_ready, mem_rvalid, mem_rdata, resp_ready,
    output req_ready, mem_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
           resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/lsu_bus_adapter.sv
// Converts single LSU load/store requests into word-aligned bus transactions with lane
// steering, load sign extension, misalignment detection and a per-transaction timeout.
module lsu_bus_adapter #(
  parameter int unsigned TIMEOUT = 64
) (
  input logic               clk,
  input logic               rst_n,
  lsu_bus_adapter_if.slave  bus
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StBusReq, StWaitRdata, StResp} state_e;

  state_e          state_q, state_d;
  logic [31:0]     addr_q, wdata_q, mask_q;
  logic            we_q, uns_q;
  logic [1:0]      size_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     resp_data_q, resp_data_d;
  logic            resp_err_q, resp_err_d;

  logic            misaligned, timeout, mem_active, store_active, resp_active;
  logic [1:0]      off;
  logic [3:0]      strb_base;
  logic [31:0]     shifted, load_result;

  // Half needs addr[0]=0; word (size bit 1 set) needs addr[1:0]=0.
  assign misaligned = ((bus.write_wstrb == 2'd1) && bus.addr[0]) ||
                      (bus.write_wstrb[1] && (bus.addr[1:0] != 2'b00));
  assign timeout    = (cnt_q == CntW'(TIMEOUT - 1));
  assign off        = addr_q[1:0];

  always_comb begin
    strb_base = 4'b1111;
    case (size_q)
      2'd0:    strb_base = 4'b0001;
      2'd1:    strb_base = 4'b0011;
      default: strb_base = 4'b1111;
    endcase
  end

  assign shifted = (bus.mem_rdata >> {off, 3'b000}) & mask_q;

  always_comb begin
    load_result = shifted;
    if (!uns_q && size_q == 2'd0) load_result = {{24{shifted[7]}}, shifted[7:0]};
    if (!uns_q && size_q == 2'd1) load_result = {{16{shifted[15]}}, shifted[15:0]};
  end

  assign mem_active    = (state_q == StBusReq);
  assign store_active  = mem_active && we_q;
  assign resp_active   = (state_q == StResp);

  assign bus.req_ready  = (state_q == StIdle);
  assign bus.mem_valid  = mem_active;
  assign bus.mem_addr   = mem_active ? {addr_q[31:2], 2'b00} : '0;
  assign bus.mem_we     = store_active;
  assign bus.mem_wstrb  = store_active ? (strb_base << off) : 4'b0000;
  assign bus.mem_wdata  = store_active ? ((wdata_q & mask_q) << {off, 3'b000}) : '0;
  assign bus.resp_valid = resp_active;
  assign bus.resp_data  = resp_active ? resp_data_q : '0;
  assign bus.resp_err   = resp_active && resp_err_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          resp_data_d = '0;
          resp_err_d  = 1'b0;
          if (!(bus.write_enable || bus.read_enable)) begin
            state_d = StResp;
          end else if (misaligned) begin
            resp_err_d = 1'b1;
            state_d    = StResp;
          end else begin
            cnt_d   = '0;
            state_d = StBusReq;
          end
        end
      end
      StBusReq: begin
        cnt_d = cnt_q + CntW'(1);
        // A handshake on the final allowed cycle still wins over the timeout.
        if (bus.mem_ready) begin
          if (we_q) begin
            state_d = StResp;
          end else if (bus.mem_rvalid) begin
            resp_data_d = load_result;
            state_d     = StResp;
          end else begin
            state_d = StWaitRdata;
          end
        end else if (timeout) begin
          resp_err_d = 1'b1;
          state_d    = StResp;
        end
      end
      StWaitRdata: begin
        cnt_d = cnt_q + CntW'(1);
        if (bus.mem_rvalid) begin
          resp_data_d = load_result;
          state_d     = StResp;
        end else if (timeout) begin
          resp_err_d = 1'b1;
          state_d    = StResp;
        end
      end
      StResp: begin
        if (bus.resp_ready) state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mask_q      <= '0;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      size_q      <= 2'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
      if (bus.req_valid && state_q == StIdle) begin
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
        mask_q  <= bus.wb_mask;
        we_q    <= bus.write_enable;
        uns_q   <= bus.load_unsigned;
        size_q  <= bus.write_wstrb;
      end
    end
  end

endmodule
